// File: rtl/tiny_nn_pkg.sv
// Shared types and helpers for the tiny_nn datapath: the 16-bit fp_t format
// (1 sign, 8 exponent, 7 mantissa, bias 127), its special values and the
// accumulator FSM state encoding.
package tiny_nn_pkg;

    localparam int FPExpWidth  = 8;
    localparam int FPMantWidth = 7;
    localparam int FPSigWidth  = FPMantWidth + 1;
    localparam int FPBias      = 127;

    typedef struct packed {
        logic                   sgn;
        logic [FPExpWidth-1:0]  exp;
        logic [FPMantWidth-1:0] mant;
    } fp_t;

    localparam fp_t FPZero   = 16'h0000;
    localparam fp_t FPStdNaN = 16'hFFFF;

    typedef enum logic [1:0] {
        AccIdle,
        AccAlign,
        AccAdd,
        AccNorm
    } fp_acc_state_e;

    // No denormals: any nonzero pattern in the exp==0 space (including -0) is NaN.
    function automatic logic is_nan(input fp_t x);
        return ((x.exp == '0) && ((x.mant != '0) || x.sgn)) ||
               ((x.exp == '1) && (x.mant != '0));
    endfunction

    function automatic logic is_inf(input fp_t x);
        return (x.exp == '1) && (x.mant == '0);
    endfunction

    function automatic logic is_zero(input fp_t x);
        return x == FPZero;
    endfunction

endpackage

// File: rtl/tiny_nn_fp_norm.sv
// Combinational normaliser: finds the leading one of the raw significand sum,
// shifts it to the top, adjusts the exponent and packs the fp_t result with
// overflow-to-inf, flush-to-zero and truncation of bits below the mantissa.
module tiny_nn_fp_norm
    import tiny_nn_pkg::*;
#(
    parameter int GuardBits = 3
) (
    input  logic [FPSigWidth+GuardBits:0] i_sum,
    input  logic signed [9:0]             i_exp,
    input  logic                          i_sgn,
    output fp_t                           o_res
);

    localparam int SumW = FPSigWidth + GuardBits + 1;
    localparam int LzW  = $clog2(SumW + 1);

    logic [LzW-1:0]         w_lzc;
    logic [SumW-1:0]        w_shifted;
    logic signed [9:0]      w_exp;
    logic [FPMantWidth-1:0] w_mant;

    // Leading-zero count: the highest set bit wins, all-zero gives SumW.
    always_comb begin
        w_lzc = LzW'(SumW);
        for (int i = 0; i < SumW; i++) begin
            if (i_sum[i]) w_lzc = LzW'(SumW - 1 - i);
        end
    end

    // The unshifted sum carries its leading one one place above the hidden bit,
    // so the exponent moves by (1 - lzc).
    assign w_shifted = i_sum << w_lzc;
    assign w_exp     = i_exp + 10'sd1 - $signed({{(10-LzW){1'b0}}, w_lzc});
    assign w_mant    = FPMantWidth'(w_shifted >> (SumW - 1 - FPMantWidth));

    // Pack the result, resolving zero, overflow and underflow.
    always_comb begin
        o_res = FPZero;
        if (i_sum == '0) begin
            o_res = FPZero;
        end else if (w_exp >= 10'sd255) begin
            o_res = '{sgn: i_sgn, exp: '1, mant: '0};
        end else if (w_exp <= 10'sd0) begin
            o_res = FPZero;
        end else begin
            o_res = '{sgn: i_sgn, exp: w_exp[FPExpWidth-1:0], mant: w_mant};
        end
    end

endmodule

// File: rtl/tiny_nn_fp_accumulator.sv
// Running fp_t accumulator built on a four-cycle serial adder:
// IDLE (accept) -> ALIGN (specials, exponent alignment) -> ADD -> NORM.
// acc_clear_i zeroes the accumulator and aborts any operation in flight.
module tiny_nn_fp_accumulator
    import tiny_nn_pkg::*;
#(
    parameter int CountWidth = 8,
    parameter int GuardBits  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  acc_clear_i,
    input  fp_t                   val_i,
    input  logic                  val_valid_i,
    output logic                  val_ready_o,
    output fp_t                   acc_o,
    output logic                  done_o,
    output logic [CountWidth-1:0] count_o
);

    localparam int SigW = FPSigWidth + GuardBits;
    localparam int SumW = SigW + 1;

    fp_acc_state_e         r_state;
    fp_t                   r_acc;
    logic [CountWidth-1:0] r_count;
    logic                  r_done;

    fp_t                   r_opnd;
    logic [SigW-1:0]       r_sig_big;
    logic [SigW-1:0]       r_sig_small;
    logic                  r_sub;
    logic                  r_sgn;
    logic signed [9:0]     r_exp;
    logic [SumW-1:0]       r_sum;
    logic                  r_special;
    fp_t                   r_special_val;

    logic                  w_acc_big;
    fp_t                   w_big;
    fp_t                   w_small;
    logic [FPExpWidth-1:0] w_diff;
    logic [SigW-1:0]       w_sig_small_raw;
    logic [SigW-1:0]       w_sig_small;
    logic                  w_special;
    fp_t                   w_special_val;
    fp_t                   w_norm_res;

    assign val_ready_o = (r_state == AccIdle) && !acc_clear_i;
    assign acc_o       = r_acc;
    assign count_o     = r_count;
    assign done_o      = r_done;

    // Order operands by magnitude and align the smaller significand.
    assign w_acc_big       = {r_acc.exp, r_acc.mant} >= {r_opnd.exp, r_opnd.mant};
    assign w_big           = w_acc_big ? r_acc : r_opnd;
    assign w_small         = w_acc_big ? r_opnd : r_acc;
    assign w_diff          = w_big.exp - w_small.exp;
    assign w_sig_small_raw = {1'b1, w_small.mant, {GuardBits{1'b0}}};
    assign w_sig_small     = (w_diff >= FPExpWidth'(SigW)) ? '0 : (w_sig_small_raw >> w_diff);

    // Special-case resolution; NaN outranks inf, inf outranks zero.
    always_comb begin
        w_special     = 1'b1;
        w_special_val = FPZero;
        if (is_nan(r_acc) || is_nan(r_opnd)) begin
            w_special_val = FPStdNaN;
        end else if (is_inf(r_acc) && is_inf(r_opnd)) begin
            w_special_val = (r_acc.sgn == r_opnd.sgn) ? r_acc : FPStdNaN;
        end else if (is_inf(r_acc)) begin
            w_special_val = r_acc;
        end else if (is_inf(r_opnd)) begin
            w_special_val = r_opnd;
        end else if (is_zero(r_acc)) begin
            w_special_val = r_opnd;
        end else if (is_zero(r_opnd)) begin
            w_special_val = r_acc;
        end else begin
            w_special = 1'b0;
        end
    end

    tiny_nn_fp_norm #(
        .GuardBits (GuardBits)
    ) u_norm (
        .i_sum (r_sum),
        .i_exp (r_exp),
        .i_sgn (r_sgn),
        .o_res (w_norm_res)
    );

    // Control: FSM, accumulator, count and done pulse; clear overrides all.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= AccIdle;
            r_acc   <= FPZero;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (acc_clear_i) begin
                r_state <= AccIdle;
                r_acc   <= FPZero;
                r_count <= '0;
            end else begin
                case (r_state)
                    AccIdle:  if (val_valid_i) r_state <= AccAlign;
                    AccAlign: r_state <= AccAdd;
                    AccAdd:   r_state <= AccNorm;
                    AccNorm: begin
                        r_state <= AccIdle;
                        r_acc   <= r_special ? r_special_val : w_norm_res;
                        r_done  <= 1'b1;
                        if (r_count != '1) r_count <= r_count + 1'b1;
                    end
                    default:  r_state <= AccIdle;
                endcase
            end
        end
    end

    // Datapath registers; each is only meaningful in the stage that loads it.
    always_ff @(posedge clk_i) begin
        if (val_valid_i && val_ready_o) begin
            r_opnd <= val_i;
        end
        if (r_state == AccAlign) begin
            r_sig_big     <= {1'b1, w_big.mant, {GuardBits{1'b0}}};
            r_sig_small   <= w_sig_small;
            r_sub         <= r_acc.sgn ^ r_opnd.sgn;
            r_sgn         <= w_big.sgn;
            r_exp         <= $signed({2'b00, w_big.exp});
            r_special     <= w_special;
            r_special_val <= w_special_val;
        end
        if (r_state == AccAdd) begin
            r_sum <= r_sub ? ({1'b0, r_sig_big} - {1'b0, r_sig_small})
                           : ({1'b0, r_sig_big} + {1'b0, r_sig_small});
        end
    end

endmodule

// File: tb/tb_tiny_nn_fp_accumulator.sv
// Directed bench for tiny_nn_fp_accumulator: expected sums are queued at
// issue and compared when done_o pulses.
module tb_tiny_nn_fp_accumulator;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr   = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] val   = 16'h0000;
    logic        ready;
    logic [15:0] acc;
    logic        done;
    logic [7:0]  cnt;

    int          n_vec   = 0;
    int          n_err   = 0;
    int          exp_cnt = 0;
    logic [15:0] q_exp[$];

    tiny_nn_fp_accumulator #(
        .CountWidth (8),
        .GuardBits  (3)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .acc_clear_i (clr),
        .val_i       (val),
        .val_valid_i (valid),
        .val_ready_o (ready),
        .acc_o       (acc),
        .done_o      (done),
        .count_o     (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        #1;
        chk("ready_in_clear", 16'(ready), 16'h0);
        tick();
        clr = 1'b0;
        exp_cnt = 0;
        q_exp.delete();
        chk("clear_acc", acc, 16'h0000);
        chk("clear_cnt", 16'(cnt), 16'h0);
        chk("clear_done", 16'(done), 16'h0);
    endtask

    // Issue one operand, check busy window and latency, then compare the result.
    task automatic feed(input logic [15:0] v, input logic [15:0] expv, input string tag);
        int          k;
        logic [15:0] e;
        k = 0;
        while (!ready && k < 10) begin
            tick();
            k++;
        end
        chk({tag, "_ready_in"}, 16'(ready), 16'h1);
        val   = v;
        valid = 1'b1;
        q_exp.push_back(expv);
        tick();
        valid = 1'b0;
        val   = 16'h0000;
        k = 1;
        while (!done && k < 8) begin
            if (k <= 3) chk({tag, "_busy"}, 16'(ready), 16'h0);
            tick();
            k++;
        end
        chk({tag, "_latency"}, 16'(k), 16'd4);
        if (exp_cnt < 255) exp_cnt++;
        e = (q_exp.size() > 0) ? q_exp.pop_front() : 16'hDEAD;
        chk({tag, "_acc"}, acc, e);
        chk({tag, "_cnt"}, 16'(cnt), 16'(exp_cnt));
        chk({tag, "_ready_out"}, 16'(ready), 16'h1);
    endtask

    task automatic watch_no_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) seen = 1'b1;
            tick();
        end
        chk(tag, 16'(seen), 16'h0);
    endtask

    initial begin
        #2;
        chk("rst_acc", acc, 16'h0000);
        chk("rst_cnt", 16'(cnt), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        #20;
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 16'(ready), 16'h1);

        do_clear();
        feed(16'h3F80, 16'h3F80, "one");
        feed(16'h4000, 16'h4040, "three");

        do_clear();
        feed(16'h3F80, 16'h3F80, "cancel_a");
        feed(16'hBF80, 16'h0000, "cancel_b");

        do_clear();
        feed(16'h3F80, 16'h3F80, "trunc_a");
        feed(16'h3B80, 16'h3F80, "trunc_b");

        do_clear();
        feed(16'h7F7F, 16'h7F7F, "ovf_a");
        feed(16'h7F7F, 16'h7F80, "ovf_b");
        feed(16'hBF80, 16'h7F80, "inf_fin");

        do_clear();
        feed(16'h7F80, 16'h7F80, "pinf");
        feed(16'hFF80, 16'hFFFF, "inf_minf");
        feed(16'h3F80, 16'hFFFF, "nan_sticky");

        do_clear();
        feed(16'h8000, 16'hFFFF, "negzero_nan");
        do_clear();
        feed(16'h0001, 16'hFFFF, "exp0_nan");

        do_clear();
        feed(16'h4040, 16'h4040, "sub_a");
        feed(16'hC000, 16'h3F80, "sub_b");

        do_clear();
        feed(16'h3FC0, 16'h3FC0, "frac_a");
        feed(16'h3F40, 16'h4010, "frac_b");

        do_clear();
        feed(16'hBF80, 16'hBF80, "neg_a");
        feed(16'hC000, 16'hC040, "neg_b");

        do_clear();
        feed(16'h00C0, 16'h00C0, "flush_a");
        feed(16'h8080, 16'h0000, "flush_b");

        // Clear during ALIGN drops the in-flight operand.
        do_clear();
        feed(16'h3F80, 16'h3F80, "abort_pre");
        val   = 16'h4000;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        clr   = 1'b1;
        #1;
        chk("abort_ready", 16'(ready), 16'h0);
        tick();
        clr = 1'b0;
        exp_cnt = 0;
        chk("abort_acc", acc, 16'h0000);
        chk("abort_cnt", 16'(cnt), 16'h0);
        chk("abort_done", 16'(done), 16'h0);
        watch_no_done("abort_no_done");

        // Valid together with clear is not accepted.
        val   = 16'h3F80;
        valid = 1'b1;
        clr   = 1'b1;
        #1;
        chk("clrvalid_ready", 16'(ready), 16'h0);
        tick();
        valid = 1'b0;
        clr   = 1'b0;
        watch_no_done("clrvalid_no_done");
        chk("clrvalid_cnt", 16'(cnt), 16'h0);
        chk("clrvalid_acc", acc, 16'h0000);
        feed(16'h4000, 16'h4000, "after_clr");

        // Asynchronous reset during NORM.
        do_clear();
        feed(16'h3F80, 16'h3F80, "arst_pre");
        val   = 16'h4000;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_acc", acc, 16'h0000);
        chk("arst_cnt", 16'(cnt), 16'h0);
        chk("arst_done", 16'(done), 16'h0);
        chk("arst_ready", 16'(ready), 16'h1);
        #2;
        rst_n = 1'b1;
        exp_cnt = 0;
        watch_no_done("arst_no_done");
        chk("arst_ready_after", 16'(ready), 16'h1);
        feed(16'h3F80, 16'h3F80, "arst_post");

        // Count saturates at all-ones.
        do_clear();
        for (int i = 0; i < 258; i++) begin
            feed(16'h0000, 16'h0000, "sat");
        end
        chk("sat_cnt", 16'(cnt), 16'h00FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
